// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, writeback flag vector layout and
// the operand-conditioning helpers used at the adder input.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_W = 4;

  // SUB/SBC add the one's complement of b
  function automatic logic op_inverts_b(input op_e op);
    return op[0];
  endfunction

  // ADD -> 0, SUB -> 1, ADC/SBC -> external carry
  function automatic logic op_carry_in(input op_e op, input logic cin);
    return op[1] ? cin : op[0];
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  alu_pkg::op_e     op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_flag;
  logic             v_flag;
  logic             z_flag;
  logic             n_flag;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, s, c_flag, v_flag, z_flag, n_flag
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, s, c_flag, v_flag, z_flag, n_flag
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/pipelined_addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; exposes the carry into its MSB so the
// final stage can derive signed overflow.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_c_msb,
  output logic             o_cout
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c[i]),
      .o_s (o_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  assign o_c_msb = w_c[CHUNK-1];
  assign o_cout  = w_c[CHUNK];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one CHUNK-bit carry segment per stage,
// flags registered with the result, whole-pipe stall on output backpressure.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  // Inter-stage registers; entry k feeds stage k+1
  logic             r_vld [PIPE];
  logic [WIDTH-1:0] r_a   [PIPE];
  logic [WIDTH-1:0] r_b   [PIPE];
  logic [WIDTH-1:0] r_sum [PIPE];
  logic             r_c   [PIPE];

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_s;
  logic [FLAG_W-1:0] r_flags;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_adv     = !r_out_valid || bus.out_ready;
  assign w_b_eff   = op_inverts_b(bus.op) ? ~bus.b : bus.b;
  assign w_cin_eff = op_carry_in(bus.op, bus.cin);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_vin;
    logic             w_ci;
    logic [CHUNK-1:0] w_a_ck;
    logic [CHUNK-1:0] w_b_ck;
    logic [WIDTH-1:0] w_lo;
    logic [CHUNK-1:0] w_sum;
    logic             w_c_msb;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc;

    if (k == 0) begin : g_first
      assign w_vin  = bus.in_valid;
      assign w_ci   = w_cin_eff;
      assign w_a_ck = bus.a[CHUNK-1:0];
      assign w_b_ck = w_b_eff[CHUNK-1:0];
      assign w_lo   = '0;
    end else begin : g_next
      assign w_vin  = r_vld[k-1];
      assign w_ci   = r_c[k-1];
      assign w_a_ck = r_a[k-1][k*CHUNK +: CHUNK];
      assign w_b_ck = r_b[k-1][k*CHUNK +: CHUNK];
      assign w_lo   = r_sum[k-1];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a     (w_a_ck),
      .i_b     (w_b_ck),
      .i_cin   (w_ci),
      .o_sum   (w_sum),
      .o_c_msb (w_c_msb),
      .o_cout  (w_cout)
    );

    always_comb begin
      w_acc                    = w_lo;
      w_acc[k*CHUNK +: CHUNK]  = w_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] w_a_fwd;
      logic [WIDTH-1:0] w_b_fwd;

      // Full operand words travel down the pipe; each stage only reads its own chunk
      if (k == 0) begin : g_src_in
        assign w_a_fwd = bus.a;
        assign w_b_fwd = w_b_eff;
      end else begin : g_src_reg
        assign w_a_fwd = r_a[k-1];
        assign w_b_fwd = r_b[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld[k] <= 1'b0;
        end else if (w_adv) begin
          r_vld[k] <= w_vin;
        end
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a[k]   <= w_a_fwd;
          r_b[k]   <= w_b_fwd;
          r_sum[k] <= w_acc;
          r_c[k]   <= w_cout;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_s         <= '0;
          r_flags     <= '0;
        end else if (w_adv) begin
          r_out_valid <= w_vin;
          if (w_vin) begin
            r_s             <= w_acc;
            r_flags[FLAG_C] <= w_cout;
            r_flags[FLAG_V] <= w_c_msb ^ w_cout;
            r_flags[FLAG_Z] <= (w_acc == '0);
            r_flags[FLAG_N] <= w_acc[WIDTH-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.c_flag    = r_flags[FLAG_C];
  assign bus.v_flag    = r_flags[FLAG_V];
  assign bus.z_flag    = r_flags[FLAG_Z];
  assign bus.n_flag    = r_flags[FLAG_N];
endmodule
